// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub with a valid/ready stream. The carry chain is cut every CHUNK bits.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow; by default the result wraps.
module addsub_pipe #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic             in_sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_r_o,
   output logic             out_carry_o,
   output logic             out_ovf_o,
   output logic             out_zero_o
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int L      = STAGES - 1;

   // Stage k registers: finished result chunks 0..k, carry out of chunk k,
   // and the still-pending upper operand chunks (skewed forward).
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  r_q [STAGES];
   logic              c_q [STAGES];
   logic [STAGES-1:0] vld_q;
   logic              ovf_q;
   logic              zero_q;

   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  r_d [STAGES];
   logic              c_d [STAGES];
   logic              cin_d [STAGES];
   logic              vld_d [STAGES];

   logic              stall;
   logic [WIDTH-1:0]  fin_r_d;
   logic              ovf_d;
   logic              sgn_a;

   assign stall       = vld_q[L] & ~out_ready_i;
   assign in_ready_o  = ~stall;
   assign out_valid_o = vld_q[L];
   assign out_r_o     = r_q[L];
   assign out_carry_o = c_q[L];
   assign out_ovf_o   = ovf_q;
   assign out_zero_o  = zero_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] r_src;
      logic [WIDTH-1:0] r_nxt;
      logic [CHUNK:0]   sum;

      if (k == 0) begin : g_head
         // Subtract as A + ~B + 1: the +1 enters as the stage-0 carry-in.
         assign a_d[k]   = in_a_i;
         assign b_d[k]   = in_b_i ^ {WIDTH{in_sub_i}};
         assign cin_d[k] = in_sub_i;
         assign vld_d[k] = in_valid_i;
         assign r_src    = '0;
      end else begin : g_body
         assign a_d[k]   = a_q[k-1];
         assign b_d[k]   = b_q[k-1];
         assign cin_d[k] = c_q[k-1];
         assign vld_d[k] = vld_q[k-1];
         assign r_src    = r_q[k-1];
      end

      assign sum = {1'b0, a_d[k][k*CHUNK +: CHUNK]}
                 + {1'b0, b_d[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, cin_d[k]};

      always_comb begin
         r_nxt = r_src;
         r_nxt[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      end

      assign r_d[k] = r_nxt;
      assign c_d[k] = sum[CHUNK];
   end

   // Same-sign operands producing an opposite-sign result is exactly cin(MSB) ^ cout(MSB).
   assign sgn_a = a_d[L][WIDTH-1];
   assign ovf_d = (sgn_a == b_d[L][WIDTH-1]) && (r_d[L][WIDTH-1] != sgn_a);

`ifdef ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   // On overflow A and B' share a sign, so A's sign is the sign of the true result.
   assign fin_r_d = ovf_d ? (sgn_a ? SAT_NEG : SAT_POS) : r_d[L];
`else
   assign fin_r_d = r_d[L];
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            r_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= vld_d[k];
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            c_q[k]   <= c_d[k];
            r_q[k]   <= (k == L) ? fin_r_d : r_d[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= (fin_r_d == '0);
      end
   end
endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. It generalises the team's fixed 4-bit ripple add/sub to any width. The carry chain is split into CHUNK-bit pipeline stages so wide operands close timing, and the block reports carry, signed overflow and zero flags per result. It sits between operand-fetch logic and the result writeback/accumulator path of the datapath.

## Interface
- WIDTH, default 16: operand and result width in bits; must be ≥ 2.
- CHUNK, default 4: bits resolved per pipeline stage; WIDTH % CHUNK must be 0. STAGES = WIDTH/CHUNK.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0: R = A + B; 1: R = A − B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_r  output  WIDTH  result.
- out_carry  output  1  carry out of the MSB (for subtract, 1 = no borrow).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_r == 0.

## Operation
- Subtract is computed as A + ~B + 1: B is inverted and the stage-0 carry-in is in_sub.
- Stage k adds chunk k of A and B' using the carry registered from stage k−1.
  - Upper operand chunks are skew-registered so each reaches its stage in the right cycle.
  - Lower result chunks are de-skew-registered so all chunks of one result appear together.
- out_carry: carry out of bit WIDTH−1.
- out_ovf: carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- out_zero: evaluated on the final out_r, including after saturation.
- Each stage holds a valid bit. Bubbles are not collapsed.
- Global stall: stall = out_valid & ~out_ready. When stall is 1, every stage register holds.
- in_ready = ~stall. It is combinational from out_valid and out_ready, with no combinational path from in_valid.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- While out_valid is 1 and out_ready is 0, out_r and all flags stay stable.
- Results leave in acceptance order. No beat is dropped or duplicated.
- Reset, including mid-operation:
  - all stage valid bits clear immediately and in-flight beats are discarded;
  - out_valid, out_r, out_carry and out_ovf go to 0, and out_zero goes to 0;
  - in_ready is 1 from the first cycle after rst_n deasserts.

## Timing
- Latency: a beat accepted at edge t produces out_valid = 1 after edge t+STAGES−1, i.e. STAGES register stages.
- Throughput: one beat per cycle while out_ready = 1.
- Concurrent accept and consume in the same cycle is legal, and the pipeline advances.
- When STAGES == 1 the block is a single registered adder with the same handshake.
- The critical path is one CHUNK-bit ripple plus the flag logic in the final stage.

## Configuration
- ADDSUB_SAT_EN defined: on signed overflow, out_r saturates.
  - To 2^(WIDTH−1)−1 if the true result is positive (A positive for add; A positive and B negative for subtract).
  - Otherwise to −2^(WIDTH−1).
  - out_ovf still reports 1. out_carry is the raw carry.
- ADDSUB_SAT_EN undefined: out_r wraps modulo 2^WIDTH.
- Latency, ports and handshake are identical in both builds.

## Test plan
All scenarios use WIDTH=8, CHUNK=4.
- Plain add: 100 + 27 → out_r 0x7F, carry 0, ovf 0, zero 0, appearing 2 cycles after accept.
- Positive overflow: 100 + 28 → ovf 1; out_r 0x80 without ADDSUB_SAT_EN, 0x7F with it.
- Negative overflow: sub −128 − 1 (0x80, 0x01) → ovf 1, carry 1; out_r 0x7F wrapped, 0x80 saturated.
- Borrow: sub 0x00 − 0x01 → 0xFF, carry 0, ovf 0. Sub 0x5A − 0x5A → 0x00, zero 1, carry 1.
- Backpressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready held 0 for 5 cycles, then 1.
  - in_ready drops while stalled; results 2, 4, 6, 8 emerge in order; none is lost or duplicated.
  - out_r stays stable while stalled.
- Reset mid-flight: pulse rst_n low with 2 beats in flight → out_valid 0 immediately, no stale result afterwards, and the next beat 7+8 → 0x0F.
